// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stage indices, FSM encoding and stall/flush masks
package pipe_ctrl_pkg;

   localparam int STG_IF1  = 0;
   localparam int STG_IF2  = 1;
   localparam int STG_ID   = 2;
   localparam int STG_EX   = 3;
   localparam int STG_MEM1 = 4;
   localparam int STG_MEM2 = 5;
   localparam int STG_WB   = 6;

   localparam int NSTG  = 7;
   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_LU     = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   localparam logic [NSTG-1:0] STALL_MEM   = 7'b0111111;
   localparam logic [NSTG-1:0] STALL_EX    = 7'b0001111;
   localparam logic [NSTG-1:0] STALL_ID    = 7'b0000111;
   localparam logic [NSTG-1:0] STALL_DRAIN = 7'b0000001;
   localparam logic [NSTG-1:0] STALL_ALL   = 7'b1111111;

   localparam logic [NSTG-1:0] FLUSH_EX    = 7'b0010000;
   localparam logic [NSTG-1:0] FLUSH_ID    = 7'b0001000;
   localparam logic [NSTG-1:0] FLUSH_DRAIN = 7'b0000100;
   localparam logic [NSTG-1:0] FLUSH_BR    = 7'b0000011;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// rtl/pipe_ctrl_sat_counter.sv - event counter that sticks at all-ones
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 7-stage pipeline stall/flush/redirect controller
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int LU_BUBBLES   = 2,
   parameter int DRAIN_CYCLES = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stallreq_id,
   input  logic            stallreq_ex,
   input  logic            stallreq_mem,
   input  logic            br,
   input  logic [31:0]     br_addr,
   input  logic            halt_req,
   output logic [NSTG-1:0] stall,
   output logic [NSTG-1:0] flush,
   output logic            redirect,
   output logic [31:0]     redirect_pc,
   output logic            halted,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     flush_cnt
);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [NSTG-1:0]  stall_raw, flush_raw;
   logic             id_hold, br_take, back_stall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      stall_raw  = '0;
      flush_raw  = '0;
      state_nxt  = state;
      cnt_nxt    = cnt;
      back_stall = stallreq_mem || stallreq_ex;
      id_hold    = ((state == ST_RUN) && stallreq_id) || (state == ST_LU);

      if (state == ST_HALTED) begin
         stall_raw = STALL_ALL;
      end else if (stallreq_mem) begin
         stall_raw = STALL_MEM;
      end else if (stallreq_ex) begin
         stall_raw = STALL_EX;
         flush_raw = FLUSH_EX;
      end else if (id_hold) begin
         stall_raw = STALL_ID;
         flush_raw = FLUSH_ID;
      end else if (state == ST_DRAIN) begin
         stall_raw = STALL_DRAIN;
         flush_raw = FLUSH_DRAIN;
      end

      br_take = br && !stall_raw[STG_ID];
      if (br_take) begin
         flush_raw = flush_raw | FLUSH_BR;
      end

      case (state)
         ST_RUN: begin
            // A hazard masked by a back-end stall still gets all of its bubbles.
            if (stallreq_id && back_stall) begin
               state_nxt = ST_LU;
               cnt_nxt   = CNT_W'(LU_BUBBLES);
            end else if (stallreq_id) begin
               if (LU_BUBBLES > 1) begin
                  state_nxt = ST_LU;
                  cnt_nxt   = CNT_W'(LU_BUBBLES - 1);
               end
            end else if (halt_req && !back_stall) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = CNT_W'(DRAIN_CYCLES - 1);
            end
         end
         ST_LU: begin
            if (!back_stall) begin
               cnt_nxt = cnt - 1'b1;
               if (cnt <= 1) begin
                  state_nxt = ST_RUN;
                  cnt_nxt   = '0;
               end
            end
         end
         ST_DRAIN: begin
            if (!halt_req) begin
               state_nxt = ST_RUN;
               cnt_nxt   = '0;
            end else if (!back_stall) begin
               if (cnt == '0) begin
                  state_nxt = ST_HALTED;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
         end
         ST_HALTED: begin
            if (!halt_req) begin
               state_nxt = ST_RUN;
            end
         end
         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign stall       = rst ? stall_raw : '0;
   assign flush       = rst ? flush_raw : '0;
   assign redirect    = rst && br_take;
   assign redirect_pc = redirect ? br_addr : 32'h0;
   assign halted      = (state == ST_HALTED);

   sat_counter #(.WIDTH(32)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall != '0),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(32)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (redirect),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stallreq_id, stallreq_ex, stallreq_mem, br, halt_req;
   logic [31:0] br_addr;
   logic [6:0]  stall, flush;
   logic        redirect, halted;
   logic [31:0] redirect_pc, stall_cnt, flush_cnt;
   logic        sat_inc;
   logic [2:0]  sat_count;

   int checks = 0;
   int errors = 0;

   pipe_ctrl #(.LU_BUBBLES(2), .DRAIN_CYCLES(5)) dut (
      .clk          (clk),
      .rst          (rst),
      .stallreq_id  (stallreq_id),
      .stallreq_ex  (stallreq_ex),
      .stallreq_mem (stallreq_mem),
      .br           (br),
      .br_addr      (br_addr),
      .halt_req     (halt_req),
      .stall        (stall),
      .flush        (flush),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc),
      .halted       (halted),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   sat_counter #(.WIDTH(3)) u_sat (
      .clk   (clk),
      .rst   (rst),
      .inc   (sat_inc),
      .count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b1;
      br = 1'b1; br_addr = 32'hDEAD_BEEF; halt_req = 1'b0; sat_inc = 1'b0;
      #2;
      check("rst_stall", 32'(stall), 32'h0);
      check("rst_flush", 32'(flush), 32'h0);
      check("rst_redirect", 32'(redirect), 32'h0);
      check("rst_pc", redirect_pc, 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      tick();
      check("rst_stall_cnt", stall_cnt, 32'h0);
      check("rst_flush_cnt", flush_cnt, 32'h0);
      stallreq_mem = 1'b0; br = 1'b0; br_addr = 32'h0;
      tick();
      rst = 1'b1;
      #2;
      check("idle_stall", 32'(stall), 32'h0);

      // load-use: two ID-hold cycles
      tick();
      stallreq_id = 1'b1; #2;
      check("lu1_stall", 32'(stall), 32'h07);
      check("lu1_flush", 32'(flush), 32'h08);
      tick();
      stallreq_id = 1'b0; #2;
      check("lu2_stall", 32'(stall), 32'h07);
      check("lu2_flush", 32'(flush), 32'h08);
      tick(); #2;
      check("lu_done_stall", 32'(stall), 32'h0);
      check("lu_stall_cnt", stall_cnt, 32'd2);

      // load-use interrupted by memory wait
      tick();
      stallreq_id = 1'b1; #2;
      check("lum1_stall", 32'(stall), 32'h07);
      for (int i = 0; i < 3; i++) begin
         tick();
         stallreq_id = 1'b0; stallreq_mem = 1'b1; #2;
         check("lum_mem_stall", 32'(stall), 32'h3F);
         check("lum_mem_flush", 32'(flush), 32'h0);
      end
      tick();
      stallreq_mem = 1'b0; #2;
      check("lum_tail_stall", 32'(stall), 32'h07);
      tick(); #2;
      check("lum_run_stall", 32'(stall), 32'h0);
      check("lum_stall_cnt", stall_cnt, 32'd7);

      // taken branch in RUN
      br = 1'b1; br_addr = 32'h0000_0100; #2;
      check("br_redirect", 32'(redirect), 32'h1);
      check("br_pc", redirect_pc, 32'h0000_0100);
      check("br_flush", 32'(flush), 32'h03);
      tick();
      br = 1'b0; #2;
      check("br_flush_cnt", flush_cnt, 32'd1);
      check("br_off_redirect", 32'(redirect), 32'h0);

      // branch blocked by EX busy, accepted once EX releases
      br = 1'b1; br_addr = 32'h0000_0200; stallreq_ex = 1'b1; #2;
      check("brex_redirect", 32'(redirect), 32'h0);
      check("brex_stall", 32'(stall), 32'h0F);
      check("brex_flush", 32'(flush), 32'h10);
      tick();
      stallreq_ex = 1'b0; #2;
      check("brex_late_redirect", 32'(redirect), 32'h1);
      check("brex_late_pc", redirect_pc, 32'h0000_0200);
      tick();
      br = 1'b0; #2;
      check("brex_flush_cnt", flush_cnt, 32'd2);

      // branch together with load-use is ignored
      br = 1'b1; br_addr = 32'h0000_0280; stallreq_id = 1'b1; #2;
      check("brid_redirect", 32'(redirect), 32'h0);
      check("brid_flush", 32'(flush), 32'h08);
      tick();
      br = 1'b0; stallreq_id = 1'b0;
      tick(); #2;
      check("brid_stall_cnt", stall_cnt, 32'd10);
      check("brid_flush_cnt", flush_cnt, 32'd2);

      // halt: drain then freeze
      halt_req = 1'b1; #2;
      check("halt_req_stall", 32'(stall), 32'h0);
      for (int i = 1; i <= 6; i++) begin
         tick();
         br = (i == 2); br_addr = 32'h0000_0300; #2;
         if (i == 1) begin
            check("drain_stall", 32'(stall), 32'h01);
            check("drain_flush", 32'(flush), 32'h04);
         end
         if (i == 2) begin
            check("drain_br_redirect", 32'(redirect), 32'h1);
            check("drain_br_flush", 32'(flush), 32'h07);
         end
         if (i == 5) check("drain_not_halted", 32'(halted), 32'h0);
      end
      check("halted", 32'(halted), 32'h1);
      check("halted_stall", 32'(stall), 32'h7F);
      halt_req = 1'b0;
      tick(); #2;
      check("unhalt_halted", 32'(halted), 32'h0);
      check("unhalt_stall", 32'(stall), 32'h0);
      check("halt_stall_cnt", stall_cnt, 32'd16);
      check("halt_flush_cnt", flush_cnt, 32'd3);

      // halt request withdrawn during drain
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0; #2;
      check("abort_drain_stall", 32'(stall), 32'h01);
      tick(); #2;
      check("abort_run_stall", 32'(stall), 32'h0);

      // reset in the middle of DRAIN
      halt_req = 1'b1;
      tick(); #2;
      check("pre_rst_drain", 32'(stall), 32'h01);
      rst = 1'b0; #1;
      check("midrst_stall", 32'(stall), 32'h0);
      check("midrst_flush", 32'(flush), 32'h0);
      check("midrst_stall_cnt", stall_cnt, 32'h0);
      tick();
      halt_req = 1'b0; rst = 1'b1; #2;
      check("post_rst_halted", 32'(halted), 32'h0);
      check("post_rst_stall", 32'(stall), 32'h0);
      stallreq_id = 1'b1; #1;
      check("post_rst_lu", 32'(stall), 32'h07);
      tick();
      stallreq_id = 1'b0;
      tick(); #2;
      check("post_rst_stall_cnt", stall_cnt, 32'd2);

      // saturation of a narrow counter
      sat_inc = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      check("sat_mid", 32'(sat_count), 32'd3);
      for (int i = 0; i < 7; i++) tick();
      check("sat_stuck", 32'(sat_count), 32'd7);
      sat_inc = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
